// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with byte-lane stores, right-aligned loads, and an MMIO
// window holding a UART transmitter with TX FIFO, a sticky status register and a cycle counter.
module dmem_ctrl #(
   parameter int unsigned RAM_WORDS  = 16384,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BAUD_DIV   = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic        mem_oe,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_we,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        uart_txd
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam logic [FW:0]   FifoFull = (FW + 1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BaudLast = BW'(BAUD_DIV - 1);

   typedef enum logic {AccIdle, AccWait} acc_e;
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_e;

   acc_e        acc_q, acc_d;
   tx_e         tx_q, tx_d;
   logic [31:0] rdata_q, rdata_d;
   logic [63:0] cnt_q;
   logic [31:0] hi_q, hi_d;
   logic        ovf_q, ovf_d;
   logic        mis_q, mis_d;
   logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FW:0]   count_q, count_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;

   logic [31:0] ram_q [RAM_WORDS];
   logic [7:0]  fifo_q [FIFO_DEPTH];

   // ---------------------------------------------------------------- request decode
   logic          is_mmio, is_store, req, misalign;
   logic          ram_we, ram_ld, mmio_ld, stat_rd, push, mis_evt;
   logic [AW-1:0] idx;
   logic [4:0]    sh_amt;
   logic [3:0]    be;
   logic [31:0]   wdata_sh;
   logic          unused_addr;

   assign unused_addr = ^mem_addr[30:4];
   assign is_mmio     = mem_addr[31];
   assign is_store    = (mem_we != 4'b0000);
   assign req         = mem_oe && (acc_q == AccIdle);
   assign misalign    = ((mem_we == 4'b0011) && mem_addr[0]) ||
                        ((mem_we == 4'b1111) && (mem_addr[1:0] != 2'b00));
   assign idx         = mem_addr[2 +: AW];
   assign sh_amt      = {mem_addr[1:0], 3'b000};
   assign be          = mem_we << mem_addr[1:0];
   assign wdata_sh    = mem_wdata << sh_amt;

   assign ram_we  = req && is_store && !misalign && !is_mmio;
   assign ram_ld  = req && !is_store && !is_mmio;
   assign mmio_ld = req && !is_store && is_mmio;
   assign stat_rd = mmio_ld && (mem_addr[3:2] == 2'd0);
   assign push    = req && is_store && !misalign && is_mmio && (mem_addr[3:2] == 2'd0);
   assign mis_evt = req && is_store && misalign;

   // ---------------------------------------------------------------- TX FIFO
   logic       full, empty, tx_ready, baud_end, pop, push_ok, ovf_evt;
   logic [7:0] tx_byte;

   assign full     = (count_q == FifoFull);
   assign empty    = (count_q == '0);
   assign baud_end = (bcnt_q == BaudLast);
   assign tx_ready = (tx_q == TxIdle) || ((tx_q == TxStop) && baud_end);
   // An empty FIFO hands a same-cycle push straight to the transmitter.
   assign pop      = tx_ready && (!empty || push);
   assign push_ok  = push && (!full || pop);
   assign ovf_evt  = push && !push_ok;
   assign tx_byte  = empty ? mem_wdata[7:0] : fifo_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------- MMIO read mux
   logic [31:0] status, mmio_rd;

   assign status = {27'd0, (tx_q != TxIdle), mis_q, ovf_q, empty, full};

   always_comb begin
      mmio_rd = '0;
      unique case (mem_addr[3:2])
         2'd0:    mmio_rd = status;
         2'd1:    mmio_rd = cnt_q[31:0];
         2'd2:    mmio_rd = hi_q;
         default: mmio_rd = '0;
      endcase
   end

   // ---------------------------------------------------------------- access FSM
   always_comb begin
      acc_d   = acc_q;
      rdata_d = rdata_q;
      hi_d    = hi_q;
      ovf_d   = ovf_q;
      mis_d   = mis_q;
      unique case (acc_q)
         AccIdle: if (mmio_ld) acc_d = AccWait;
         AccWait: acc_d = AccIdle;
         default: acc_d = AccIdle;
      endcase
      if (ram_ld) begin
         rdata_d = ram_q[idx] >> sh_amt;
      end else if (mmio_ld) begin
         rdata_d = mmio_rd;
      end
      if (mmio_ld && (mem_addr[3:2] == 2'd1)) hi_d = cnt_q[63:32];
      // Clear-on-read happens first so an event in the same cycle stays visible.
      if (stat_rd) begin
         ovf_d = 1'b0;
         mis_d = 1'b0;
      end
      if (ovf_evt) ovf_d = 1'b1;
      if (mis_evt) mis_d = 1'b1;
   end

   // ---------------------------------------------------------------- UART TX FSM
   always_comb begin
      tx_d   = tx_q;
      bcnt_d = (tx_q == TxIdle || baud_end) ? '0 : bcnt_q + 1'b1;
      bit_d  = bit_q;
      sh_d   = sh_q;
      unique case (tx_q)
         TxIdle: begin
            if (pop) begin
               tx_d = TxStart;
               sh_d = tx_byte;
            end
         end
         TxStart: begin
            if (baud_end) begin
               tx_d  = TxData;
               bit_d = 3'd0;
            end
         end
         TxData: begin
            if (baud_end) begin
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) tx_d = TxStop;
            end
         end
         TxStop: begin
            if (baud_end) begin
               if (pop) begin
                  tx_d = TxStart;
                  sh_d = tx_byte;
               end else begin
                  tx_d = TxIdle;
               end
            end
         end
         default: tx_d = TxIdle;
      endcase
   end

   always_comb begin
      uart_txd = 1'b1;
      unique case (tx_q)
         TxStart: uart_txd = 1'b0;
         TxData:  uart_txd = sh_q[0];
         default: uart_txd = 1'b1;
      endcase
   end

   assign mem_ready = (acc_q != AccWait);
   assign mem_rdata = rdata_q;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= AccIdle;
         rdata_q  <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         ovf_q    <= 1'b0;
         mis_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tx_q     <= TxIdle;
         bcnt_q   <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
      end else begin
         acc_q    <= acc_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_q + 64'd1;
         hi_q     <= hi_d;
         ovf_q    <= ovf_d;
         mis_q    <= mis_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tx_q     <= tx_d;
         bcnt_q   <= bcnt_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: RAM load/store alignment, MMIO wait cycle, sticky flags,
// cycle counter and UART framing, observed through a small serial receiver.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic        mem_oe;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        uart_txd;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] rx_q [$];
   logic [7:0] rx_byte;

   dmem_ctrl #(
      .RAM_WORDS (256),
      .FIFO_DEPTH(16),
      .BAUD_DIV  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_addr (mem_addr),
      .mem_oe   (mem_oe),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .uart_txd (uart_txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
      mem_addr  = addr;
      mem_we    = we;
      mem_wdata = wd;
      mem_oe    = 1'b1;
      cycle();
      mem_oe = 1'b0;
      mem_we = 4'b0000;
   endtask

   task automatic ld(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      access(addr, 4'b0000, 32'h0);
      check({tag, "_ready"}, mem_ready, 1'b1);
      check(tag, mem_rdata, exp);
   endtask

   task automatic mmio_rd(input string tag, input logic [31:0] addr, output logic [31:0] data);
      access(addr, 4'b0000, 32'h0);
      check({tag, "_wait"}, mem_ready, 1'b0);
      cycle();
      check({tag, "_ready"}, mem_ready, 1'b1);
      data = mem_rdata;
   endtask

   // Serial receiver, mid-bit sampling at BAUD_DIV=4.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && uart_txd == 1'b0) begin
            repeat (2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (4) @(negedge clk);
               rx_byte[b] = uart_txd;
            end
            repeat (4) @(negedge clk);
            rx_q.push_back(rx_byte);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, l1, l2, h;
      logic [40:0] got_v, exp_v;
      logic [7:0]  v;
      logic        seen0;

      rst = 1'b0; mem_addr = '0; mem_oe = 1'b0; mem_wdata = '0; mem_we = '0;
      #3;
      check("rst_ready", mem_ready, 1'b1);
      check("rst_rdata", mem_rdata, 32'h0);
      check("rst_txd", uart_txd, 1'b1);
      cycle();
      rst = 1'b1;

      // RAM stores and loads
      access(32'h10, 4'b1111, 32'h1234_5678);
      ld("lw_10", 32'h10, 32'h1234_5678);
      access(32'h13, 4'b0001, 32'h0000_00AB);
      ld("lw_after_sb", 32'h10, 32'hAB34_5678);
      ld("lb_13", 32'h13, 32'h0000_00AB);
      ld("lw_misaligned", 32'h11, 32'h00AB_3456);
      ld("lw_wrap", 32'h410, 32'hAB34_5678);
      access(32'h20, 4'b1111, 32'h0);
      access(32'h22, 4'b0011, 32'h0000_BEEF);
      ld("lw_after_sh", 32'h20, 32'hBEEF_0000);
      ld("lh_22", 32'h22, 32'h0000_BEEF);

      // Misaligned stores leave memory alone and set the sticky flag
      access(32'h13, 4'b0011, 32'h0000_FFFF);
      access(32'h11, 4'b1111, 32'hFFFF_FFFF);
      ld("lw_after_missh", 32'h10, 32'hAB34_5678);
      mmio_rd("stat_mis", 32'h8000_0000, d);
      check("stat_mis_val", d, 32'h0000_000A);
      mmio_rd("stat_mis2", 32'h8000_0000, d);
      check("stat_mis2_val", d, 32'h0000_0002);

      // Store during the wait cycle is dropped; store in the following cycle executes
      access(32'h34, 4'b1111, 32'h0);
      mem_addr = 32'h8000_0000; mem_we = 4'b0000; mem_oe = 1'b1;
      cycle();
      check("wait_ready", mem_ready, 1'b0);
      mem_addr = 32'h34; mem_we = 4'b1111; mem_wdata = 32'hDEAD_BEEF;
      cycle();
      check("after_wait_ready", mem_ready, 1'b1);
      check("after_wait_rdata", mem_rdata, 32'h0000_0002);
      mem_addr = 32'h30; mem_we = 4'b1111; mem_wdata = 32'h1111_1111;
      cycle();
      mem_oe = 1'b0; mem_we = 4'b0000;
      ld("wait_store_ignored", 32'h34, 32'h0);
      ld("next_store_done", 32'h30, 32'h1111_1111);

      // Cycle counter
      mmio_rd("cnt_lo1", 32'h8000_0004, l1);
      mmio_rd("cnt_hi", 32'h8000_0008, h);
      mmio_rd("cnt_lo2", 32'h8000_0004, l2);
      check("cnt_hi_val", h, 32'h0);
      check("cnt_delta", l2 - l1, 32'd4);
      mmio_rd("unmapped", 32'h8000_000C, d);
      check("unmapped_val", d, 32'h0);

      // One frame of 0x55
      rx_q.delete();
      access(32'h8000_0000, 4'b0001, 32'h0000_0055);
      for (int i = 0; i < 41; i++) begin
         got_v[i] = uart_txd;
         if (i < 4) exp_v[i] = 1'b0;
         else if (i < 36) begin
            v = 8'h55;
            exp_v[i] = v[(i - 4) / 4];
         end else exp_v[i] = 1'b1;
         cycle();
      end
      check("frame_55", got_v, exp_v);
      check("rx_55_cnt", rx_q.size(), 1);
      v = (rx_q.size() != 0) ? rx_q[0] : 8'hxx;
      check("rx_55_val", v, 8'h55);

      // Busy flag during a frame
      access(32'h8000_0000, 4'b0001, 32'h0000_00A5);
      mmio_rd("stat_busy", 32'h8000_0000, d);
      check("stat_busy_val", d, 32'h0000_0012);
      repeat (50) cycle();
      mmio_rd("stat_idle", 32'h8000_0000, d);
      check("stat_idle_val", d, 32'h0000_0002);

      // Overflow: 18 pushes, one goes straight to the transmitter, 16 fill the FIFO
      rx_q.delete();
      for (int i = 0; i < 18; i++) access(32'h8000_0000, 4'b0001, i);
      mmio_rd("stat_ovf", 32'h8000_0000, d);
      check("stat_ovf_val", d, 32'h0000_0015);
      mmio_rd("stat_ovf2", 32'h8000_0000, d);
      check("stat_ovf2_val", d, 32'h0000_0011);
      for (int t = 0; t < 1200 && rx_q.size() < 17; t++) cycle();
      repeat (100) cycle();
      check("rx_frames", rx_q.size(), 17);
      for (int i = 0; i < 17; i++) begin
         v = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
         check($sformatf("rx_byte%0d", i), v, 8'(i));
      end
      mmio_rd("stat_drained", 32'h8000_0000, d);
      check("stat_drained_val", d, 32'h0000_0002);

      // Reset mid-frame
      access(32'h8000_0000, 4'b0001, 32'h0000_003C);
      access(32'h8000_0000, 4'b0001, 32'h0000_003D);
      repeat (10) cycle();
      check("pre_rst_txd", uart_txd, 1'b0);
      rst = 1'b0;
      #1;
      check("mid_rst_txd", uart_txd, 1'b1);
      check("mid_rst_ready", mem_ready, 1'b1);
      check("mid_rst_rdata", mem_rdata, 32'h0);
      cycle();
      rst = 1'b1;
      mmio_rd("cnt_after_rst", 32'h8000_0004, l1);
      check("cnt_after_rst_val", l1, 32'd0);
      mmio_rd("stat_after_rst", 32'h8000_0000, d);
      check("stat_after_rst_val", d, 32'h0000_0002);
      mmio_rd("cnt_after_rst2", 32'h8000_0004, l2);
      check("cnt_after_rst2_val", l2, 32'd4);
      seen0 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (uart_txd == 1'b0) seen0 = 1'b1;
         cycle();
      end
      check("txd_idle_after_rst", seen0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
